// File: rtl/step_pulse_scheduler.sv
//------------------------------------------------------------------------------
// Module  : step_pulse_scheduler
// Brief   : Accumulator-based step pulse generator with per-second bookkeeping.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module step_pulse_scheduler #(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  mode,
    output logic        si,
    output logic        sec_tick,
    output logic [13:0] sec_count,
    output logic [7:0]  rate,
    output logic [1:0]  state
);

    localparam int C_CYC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int C_ACC_W = $clog2(CLK_HZ) + 1;
    localparam logic [C_CYC_W-1:0] C_CYC_LAST = C_CYC_W'(CLK_HZ - 1);
    localparam logic [C_ACC_W-1:0] C_ACC_HZ   = C_ACC_W'(CLK_HZ);
    localparam logic [13:0]        C_SEC_MAX  = 14'd9999;
    localparam logic [3:0]         C_HIDX_END = 4'd9;
    localparam logic [1:0]         C_HYBRID   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_mode;
    logic [C_CYC_W-1:0]   r_cyc;
    logic [C_ACC_W-1:0]   r_acc;
    logic [3:0]           r_hidx;

    logic [C_ACC_W-1:0]   w_sum;
    logic [3:0]           w_hidx_nx;
    logic                 w_mode_chg;

    function automatic logic [7:0] hybrid_rate(input logic [3:0] idx);
        case (idx)
            4'd0:    hybrid_rate = 8'd20;
            4'd1:    hybrid_rate = 8'd33;
            4'd2:    hybrid_rate = 8'd66;
            4'd3:    hybrid_rate = 8'd27;
            4'd4:    hybrid_rate = 8'd70;
            4'd5:    hybrid_rate = 8'd30;
            4'd6:    hybrid_rate = 8'd19;
            4'd7:    hybrid_rate = 8'd30;
            4'd8:    hybrid_rate = 8'd33;
            default: hybrid_rate = 8'd0;
        endcase
    endfunction

    always_comb begin
        rate = 8'd0;
        if (r_state == RUN || r_state == PAUSE) begin
            case (r_mode)
                2'd0:    rate = 8'd32;
                2'd1:    rate = 8'd64;
                2'd2:    rate = 8'd128;
                default: rate = hybrid_rate(r_hidx);
            endcase
        end
    end

    assign w_sum      = r_acc + C_ACC_W'(rate);
    assign w_hidx_nx  = (r_hidx >= C_HIDX_END) ? C_HIDX_END : r_hidx + 4'd1;
    assign w_mode_chg = (r_state != IDLE) && (mode != r_mode);
    assign sec_tick   = (r_state == RUN || r_state == DONE) && (r_cyc == C_CYC_LAST);
    assign state      = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mode    <= 2'd0;
            r_cyc     <= '0;
            r_acc     <= '0;
            r_hidx    <= 4'd0;
            si        <= 1'b0;
            sec_count <= 14'd0;
        end else begin
            r_mode <= mode;
            si     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_cyc   <= '0;
                        r_acc   <= '0;
                        r_hidx  <= 4'd0;
                    end
                end
                default: begin
                    if (r_state == RUN && start) begin
                        r_cyc <= r_cyc + 1'b1;
                        if (w_sum >= C_ACC_HZ) begin
                            r_acc <= w_sum - C_ACC_HZ;
                            si    <= 1'b1;
                        end else begin
                            r_acc <= w_sum;
                        end
                    end else if (r_state == DONE) begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                    // The second wrap overrides the accumulator update above,
                    // but the pulse for this edge was already taken from it.
                    if (sec_tick) begin
                        r_cyc <= '0;
                        r_acc <= '0;
                        if (sec_count != C_SEC_MAX)
                            sec_count <= sec_count + 1'b1;
                        if (r_mode == C_HYBRID)
                            r_hidx <= w_hidx_nx;
                    end
                    if (r_state == RUN && sec_tick && r_mode == C_HYBRID && w_hidx_nx == C_HIDX_END)
                        r_state <= DONE;
                    else if (r_state == RUN && !start)
                        r_state <= PAUSE;
                    else if (r_state == PAUSE && start)
                        r_state <= RUN;
                    if (w_mode_chg) begin
                        r_cyc  <= '0;
                        r_acc  <= '0;
                        r_hidx <= 4'd0;
                        si     <= 1'b0;
                        r_state <= (r_state == DONE || start) ? RUN : PAUSE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
